// File: rtl/utmi_tx_nrzi_stuffer.sv
// ---------------------------------------------------------------------------
// utmi_tx_nrzi_stuffer
//
// Transmit-side line encoder for a UTMI-style USB full-speed PHY. Takes one
// serial NRZ bit per USB bit time (LSB first), inserts a stuffed zero after
// six consecutive ones, NRZI-encodes the result onto dp/dm and appends the
// end-of-packet sequence (SE0 for two bit times, then J for one bit time).
//
// Ports
//   Clk         in   transmit clock, 4 Clk cycles per USB bit time
//   Rst         in   asynchronous, active-low reset
//   edge_count  in   [1:0] bit-phase counter; a bit boundary (strobe) is
//                    the Clk edge on which edge_count == 3
//   tx_valid    in   packet transmit active (level)
//   data_in     in   serial NRZ data bit, LSB first
//   eop_enable  in   request EOP after the last data bit (level)
//   stuff       out  stuffed bit in progress; upstream holds its bit counter
//   dp, dm      out  line state: J = (1,0), K = (0,1), SE0 = (0,0)
//   tx_oe       out  line driver enable
//   eop_done    out  one-Clk pulse when the EOP sequence has finished
//   busy        out  high whenever the encoder is not idle
// ---------------------------------------------------------------------------
module utmi_tx_nrzi_stuffer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] edge_count,
  input  logic       tx_valid,
  input  logic       data_in,
  input  logic       eop_enable,
  output logic       stuff,
  output logic       dp,
  output logic       dm,
  output logic       tx_oe,
  output logic       eop_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  state_t     state_q;
  logic       dp_q;
  logic       dm_q;
  logic       tx_oe_q;
  logic       stuff_q;
  logic       eop_done_q;
  logic       busy_q;
  logic [2:0] ones_q;     // consecutive ones placed on the line
  logic       se0_cnt_q;  // bit times of SE0 already completed

  logic       strobe;
  logic [2:0] ones_d;
  logic       ones_hit_six;

  // Bit boundary: every line change happens on this edge only.
  assign strobe       = (edge_count == 2'd3);

  // Count value if the current data bit is a 1. The counter never exceeds 6
  // because reaching 6 forces a stuffed 0 on the very next strobe.
  assign ones_d       = ones_q + 3'd1;
  assign ones_hit_six = (ones_d == 3'd6);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      tx_oe_q    <= 1'b0;
      stuff_q    <= 1'b0;
      eop_done_q <= 1'b0;
      busy_q     <= 1'b0;
      ones_q     <= 3'd0;
      se0_cnt_q  <= 1'b0;
    end else begin
      // eop_done is a single-cycle pulse; only the EOP_J exit raises it.
      eop_done_q <= 1'b0;

      case (state_q)
        // -------------------------------------------------------------
        // Idle: line parked at J, driver off. eop_enable has no effect.
        // -------------------------------------------------------------
        IDLE: begin
          dp_q      <= 1'b1;
          dm_q      <= 1'b0;
          tx_oe_q   <= 1'b0;
          stuff_q   <= 1'b0;
          busy_q    <= 1'b0;
          ones_q    <= 3'd0;
          se0_cnt_q <= 1'b0;
          if (strobe && tx_valid) begin
            // The first bit is encoded on the same strobe that starts the
            // packet. The previous line state is J, so a 0 gives K and a 1
            // keeps J.
            state_q <= DATA;
            busy_q  <= 1'b1;
            tx_oe_q <= 1'b1;
            if (data_in) begin
              ones_q <= 3'd1;
            end else begin
              dp_q <= 1'b0;
              dm_q <= 1'b1;
            end
          end
        end

        // -------------------------------------------------------------
        // Data: NRZI encode with bit stuffing.
        // -------------------------------------------------------------
        DATA: begin
          if (!tx_valid) begin
            // Abort takes effect on the next Clk edge, not on a strobe.
            state_q <= IDLE;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            tx_oe_q <= 1'b0;
            stuff_q <= 1'b0;
            busy_q  <= 1'b0;
            ones_q  <= 3'd0;
          end else if (strobe) begin
            if (stuff_q) begin
              // Stuffed 0: toggle regardless of data_in. Any EOP request
              // seen here waits for the following strobe, so the stuffed
              // bit is always completed before SE0.
              dp_q    <= ~dp_q;
              dm_q    <= ~dm_q;
              ones_q  <= 3'd0;
              stuff_q <= 1'b0;
            end else if (eop_enable) begin
              state_q   <= EOP_SE0;
              dp_q      <= 1'b0;
              dm_q      <= 1'b0;
              se0_cnt_q <= 1'b0;
            end else if (!data_in) begin
              dp_q   <= ~dp_q;
              dm_q   <= ~dm_q;
              ones_q <= 3'd0;
            end else begin
              // A 1 holds the line; the sixth one in a row schedules a
              // stuffed 0 and tells upstream to hold its next bit.
              ones_q <= ones_d;
              if (ones_hit_six) begin
                stuff_q <= 1'b1;
              end
            end
          end
        end

        // -------------------------------------------------------------
        // EOP: two bit times of SE0. tx_valid is ignored from here on.
        // -------------------------------------------------------------
        EOP_SE0: begin
          if (strobe) begin
            if (se0_cnt_q) begin
              state_q <= EOP_J;
              dp_q    <= 1'b1;
              dm_q    <= 1'b0;
            end else begin
              se0_cnt_q <= 1'b1;
            end
          end
        end

        // -------------------------------------------------------------
        // EOP: one bit time of J, then release the line.
        // -------------------------------------------------------------
        EOP_J: begin
          if (strobe) begin
            state_q    <= IDLE;
            tx_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            eop_done_q <= 1'b1;
            ones_q     <= 3'd0;
            se0_cnt_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stuff    = stuff_q;
  assign dp       = dp_q;
  assign dm       = dm_q;
  assign tx_oe    = tx_oe_q;
  assign eop_done = eop_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_utmi_tx_nrzi_stuffer.sv
// ---------------------------------------------------------------------------
// tb_utmi_tx_nrzi_stuffer
//
// Directed bench for utmi_tx_nrzi_stuffer. Expected line states are written
// out by hand for each step; comparisons are immediate assertions.
// ---------------------------------------------------------------------------
module tb_utmi_tx_nrzi_stuffer;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] edge_count = 2'd0;
  logic       tx_valid;
  logic       data_in;
  logic       eop_enable;
  logic       stuff;
  logic       dp;
  logic       dm;
  logic       tx_oe;
  logic       eop_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Counters sampled on the falling edge, away from the active edge.
  int stuff_hi_n = 0;
  int eop_done_n = 0;

  utmi_tx_nrzi_stuffer dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .edge_count (edge_count),
    .tx_valid   (tx_valid),
    .data_in    (data_in),
    .eop_enable (eop_enable),
    .stuff      (stuff),
    .dp         (dp),
    .dm         (dm),
    .tx_oe      (tx_oe),
    .eop_done   (eop_done),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // Free-running bit-phase counter, as the upstream PHY logic provides.
  always @(posedge Clk) edge_count <= edge_count + 2'd1;

  always @(negedge Clk) begin
    if (stuff)    stuff_hi_n <= stuff_hi_n + 1;
    if (eop_done) eop_done_n <= eop_done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the falling edge just before a strobe edge.
  task automatic to_strobe();
    do @(negedge Clk); while (edge_count != 2'd3);
  endtask

  // Present one bit time of inputs, step through the strobe edge and stop
  // 1 time unit after it so outputs can be compared.
  task automatic strobe_bit(input logic d, input logic eop);
    to_strobe();
    data_in    = d;
    eop_enable = eop;
    @(posedge Clk);
    #1;
  endtask

  logic [15:0] stream;
  logic [1:0]  exp_line [17];
  logic        exp_stuff [17];
  logic        was_stuff;
  int          idx;
  int          snap;
  logic        seen;

  initial begin
    Rst        = 1'b1;
    tx_valid   = 1'b0;
    data_in    = 1'b0;
    eop_enable = 1'b0;

    // Asynchronous reset before any Clk edge.
    #2 Rst = 1'b0;
    #1;
    chk("rst_line",     {dp, dm}, LJ);
    chk("rst_tx_oe",    tx_oe,    1'b0);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_stuff",    stuff,    1'b0);
    chk("rst_eop_done", eop_done, 1'b0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;

    // eop_enable in IDLE is ignored.
    strobe_bit(1'b0, 1'b1);
    chk("idle_eop_busy",  busy,     1'b0);
    chk("idle_eop_line",  {dp, dm}, LJ);
    chk("idle_eop_tx_oe", tx_oe,    1'b0);
    eop_enable = 1'b0;

    // SYNC (0000_0001 LSB first) followed by 0xFF. Upstream holds its bit
    // index while stuff is high.
    stream    = {8'hFF, 8'h80};
    exp_line  = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
                  LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ};
    exp_stuff = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 1, 0, 0, 0, 0};
    idx      = 0;
    snap     = stuff_hi_n;
    tx_valid = 1'b1;
    for (int s = 0; s < 17; s++) begin
      was_stuff = stuff;
      strobe_bit(stream[idx[3:0]], 1'b0);
      if (!was_stuff) idx++;
      chk($sformatf("sync_ff_line[%0d]", s),  {dp, dm}, exp_line[s]);
      chk($sformatf("sync_ff_stuff[%0d]", s), stuff,    exp_stuff[s]);
      chk($sformatf("sync_ff_tx_oe[%0d]", s), tx_oe,    1'b1);
    end
    chk("sync_ff_bits_consumed", idx, 16);
    chk("sync_ff_stuff_clks",    stuff_hi_n - snap, 4);

    // Data 0 then EOP. tx_valid drops during SE0 and must be ignored.
    strobe_bit(1'b0, 1'b0);
    chk("pre_eop_line", {dp, dm}, LK);
    strobe_bit(1'b1, 1'b1);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin
        @(posedge Clk);
        #1;
      end
      chk($sformatf("eop_line[%0d]", c),     {dp, dm}, (c < 8) ? LSE0 : LJ);
      chk($sformatf("eop_tx_oe[%0d]", c),    tx_oe,    (c < 12) ? 1'b1 : 1'b0);
      chk($sformatf("eop_busy[%0d]", c),     busy,     (c < 12) ? 1'b1 : 1'b0);
      chk($sformatf("eop_done[%0d]", c),     eop_done, (c == 12) ? 1'b1 : 1'b0);
      if (c == 3) tx_valid = 1'b0;
    end
    eop_enable = 1'b0;

    // EOP requested on the strobe where a stuffed bit is pending.
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      strobe_bit(1'b1, 1'b0);
      chk($sformatf("stuffeop_line[%0d]", i),  {dp, dm}, LJ);
      chk($sformatf("stuffeop_stuff[%0d]", i), stuff,    (i == 5) ? 1'b1 : 1'b0);
    end
    strobe_bit(1'b1, 1'b1);
    chk("stuffeop_toggle_line",  {dp, dm}, LK);
    chk("stuffeop_toggle_stuff", stuff,    1'b0);
    chk("stuffeop_toggle_busy",  busy,     1'b1);
    strobe_bit(1'b1, 1'b1);
    chk("stuffeop_se0_line",  {dp, dm}, LSE0);
    chk("stuffeop_se0_tx_oe", tx_oe,    1'b1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clk);
      if (eop_done) seen = 1'b1;
    end
    chk("stuffeop_done_seen", seen, 1'b1);
    eop_enable = 1'b0;
    tx_valid   = 1'b0;

    // Abort mid-byte while a stuffed bit is pending.
    tx_valid = 1'b1;
    strobe_bit(1'b0, 1'b0);
    chk("abort_first_line", {dp, dm}, LK);
    for (int i = 0; i < 6; i++) strobe_bit(1'b1, 1'b0);
    chk("abort_pre_stuff", stuff, 1'b1);
    snap = eop_done_n;
    @(negedge Clk);
    tx_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort_line",     {dp, dm}, LJ);
    chk("abort_tx_oe",    tx_oe,    1'b0);
    chk("abort_busy",     busy,     1'b0);
    chk("abort_stuff",    stuff,    1'b0);
    chk("abort_eop_done", eop_done, 1'b0);
    repeat (12) @(posedge Clk);
    #1;
    chk("abort_no_eop_done", eop_done_n - snap, 0);

    // Reset asserted mid-DATA, checked before any further Clk edge.
    tx_valid = 1'b1;
    strobe_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) strobe_bit(1'b1, 1'b0);
    chk("rstmid_pre_line",  {dp, dm}, LK);
    chk("rstmid_pre_stuff", stuff,    1'b1);
    @(negedge Clk);
    #1 Rst = 1'b0;
    #1;
    chk("rstmid_line",     {dp, dm}, LJ);
    chk("rstmid_tx_oe",    tx_oe,    1'b0);
    chk("rstmid_busy",     busy,     1'b0);
    chk("rstmid_stuff",    stuff,    1'b0);
    chk("rstmid_eop_done", eop_done, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;

    // Restart goes through IDLE->DATA with a fresh ones counter.
    strobe_bit(1'b1, 1'b0);
    chk("restart_line",  {dp, dm}, LJ);
    chk("restart_tx_oe", tx_oe,    1'b1);
    chk("restart_busy",  busy,     1'b1);
    for (int i = 0; i < 4; i++) strobe_bit(1'b1, 1'b0);
    chk("restart_five_ones_stuff", stuff, 1'b0);
    strobe_bit(1'b1, 1'b0);
    chk("restart_six_ones_stuff", stuff, 1'b1);
    tx_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
